// File: rtl/ca_corr_pkg.sv
// ---------------------------------------------------------------------------
// ca_corr_pkg
// Shared definitions for the GPS L1 C/A prompt correlator:
//   corr_state_t  - correlator control states
//   CA_CODE_LEN   - chips per C/A code period (1 epoch = 1 ms)
//   EPOCH_W       - width of the epoch counter (covers up to 20 epochs)
//   WIDE_W        - internal width used for overflow-free arithmetic
//   chip_to_sign  - maps a C/A chip bit to +1 / -1
//   sat_add       - signed add clamped to a given two's-complement width
// ---------------------------------------------------------------------------
package ca_corr_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_EPOCH = 2'd1,
    ACCUM      = 2'd2
  } corr_state_t;

  localparam int CA_CODE_LEN = 1023;
  localparam int EPOCH_W     = 5;
  localparam int WIDE_W      = 64;

  // Chip 0 carries +1, chip 1 carries -1.
  function automatic logic signed [1:0] chip_to_sign(input logic chip);
    return chip ? -2'sd1 : 2'sd1;
  endfunction

  // Adds in a wide domain (cannot overflow there) and clamps the result to
  // the range of a 'width'-bit signed number.
  function automatic logic signed [WIDE_W-1:0] sat_add(
    input logic signed [WIDE_W-1:0] acc,
    input logic signed [WIDE_W-1:0] val,
    input int                       width
  );
    logic signed [WIDE_W-1:0] sum;
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    sum   = acc + val;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (sum > max_v)      return max_v;
    else if (sum < min_v) return min_v;
    else                  return sum;
  endfunction

endpackage

// File: rtl/ca_corr_acc.sv
// ---------------------------------------------------------------------------
// ca_corr_acc
// One correlator arm: wipes the C/A chip off a baseband sample (multiply by
// +1/-1) and integrates the product in a saturating signed accumulator.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - force accumulator to 0 (highest priority)
//   restart     - load accumulator with this sample's product
//   add         - accumulate this sample's product
//   chip        - prompt chip aligned to the sample
//   sample      - signed baseband sample
//   acc         - current accumulator value
// ---------------------------------------------------------------------------
module ca_corr_acc
  import ca_corr_pkg::*;
#(
  parameter int SAMPLE_W = 3,
  parameter int ACC_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       restart,
  input  logic                       add,
  input  logic                       chip,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [ACC_W-1:0]    acc
);

  logic signed [1:0]        sign;
  logic signed [WIDE_W-1:0] samp_w;
  logic signed [WIDE_W-1:0] prod_w;
  logic signed [WIDE_W-1:0] sum_w;
  logic signed [WIDE_W-1:0] first_w;

  // The sample is sign-extended before negation so that negating the most
  // negative sample value gives a representable positive result.
  always_comb begin
    sign    = chip_to_sign(chip);
    samp_w  = WIDE_W'(sample);
    prod_w  = sign[1] ? -samp_w : samp_w;
    sum_w   = sat_add(WIDE_W'(acc), prod_w, ACC_W);
    first_w = sat_add('0, prod_w, ACC_W);
  end

  // NOTE: flops are written with non-blocking (<=) so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (restart) begin
      acc <= ACC_W'(first_w);
    end else if (add) begin
      acc <= ACC_W'(sum_w);
    end
  end

endmodule

// File: rtl/ca_prompt_correlator.sv
// ---------------------------------------------------------------------------
// ca_prompt_correlator
// Prompt correlator downstream of the GPS L1 C/A code generator. Integrates
// chip-wiped I/Q samples over NUM_EPOCHS code epochs, aligned to the code
// epoch, and hands the result over a valid/ready interface.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   en_i              - enable; low aborts the integration and idles
//   sample_valid_i    - qualifies sample_i_i, sample_q_i, chip_i, epoch_i
//   sample_i_i/_q_i   - signed baseband samples
//   chip_i            - prompt chip (0 -> +1, 1 -> -1)
//   epoch_i           - sample is the first of a new code period
//   dump_valid_o      - dump registers hold an unconsumed result
//   dump_ready_i      - consumer accepts the dump
//   dump_i_o/_q_o     - integrated I / Q
//   dump_cnt_o        - number of samples in the dump
//   overrun_o         - sticky: a dump was dropped due to backpressure
// ---------------------------------------------------------------------------
module ca_prompt_correlator
  import ca_corr_pkg::*;
#(
  parameter int SAMPLE_W   = 3,
  parameter int ACC_W      = 16,
  parameter int CNT_W      = 16,
  parameter int NUM_EPOCHS = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic                       sample_valid_i,
  input  logic signed [SAMPLE_W-1:0] sample_i_i,
  input  logic signed [SAMPLE_W-1:0] sample_q_i,
  input  logic                       chip_i,
  input  logic                       epoch_i,
  output logic                       dump_valid_o,
  input  logic                       dump_ready_i,
  output logic signed [ACC_W-1:0]    dump_i_o,
  output logic signed [ACC_W-1:0]    dump_q_o,
  output logic [CNT_W-1:0]           dump_cnt_o,
  output logic                       overrun_o
);

  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(NUM_EPOCHS - 1);

  corr_state_t              state_q;
  corr_state_t              state_d;
  logic [EPOCH_W-1:0]       epoch_cnt;
  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc_i;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     acc_clear;
  logic                     acc_restart;
  logic                     acc_add;
  logic                     dump_fire;
  logic                     dump_take;

  // Control decode. en_i low overrides everything, including a coincident
  // epoch sample, so an abort never produces a dump.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    acc_clear   = 1'b0;
    acc_restart = 1'b0;
    acc_add     = 1'b0;
    dump_fire   = 1'b0;
    if (!en_i) begin
      state_d   = IDLE;
      acc_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_clear = 1'b1;
          state_d   = WAIT_EPOCH;
        end
        WAIT_EPOCH: begin
          if (sample_valid_i && epoch_i) begin
            acc_restart = 1'b1;
            state_d     = ACCUM;
          end
        end
        ACCUM: begin
          if (sample_valid_i) begin
            if (epoch_i && (epoch_cnt == EPOCH_LAST)) begin
              dump_fire   = 1'b1;
              acc_restart = 1'b1;
            end else begin
              acc_add = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A dump is accepted into the output registers only if they are free or
  // being emptied on this very edge; otherwise it is lost.
  assign dump_take = dump_fire && (!dump_valid_o || dump_ready_i);

  ca_corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .restart (acc_restart),
    .add     (acc_add),
    .chip    (chip_i),
    .sample  (sample_i_i),
    .acc     (acc_i)
  );

  ca_corr_acc #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_acc_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .restart (acc_restart),
    .add     (acc_add),
    .chip    (chip_i),
    .sample  (sample_q_i),
    .acc     (acc_q)
  );

  // State, epoch counter and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      epoch_cnt <= '0;
      cnt       <= '0;
    end else begin
      state_q <= state_d;
      if (acc_clear) begin
        epoch_cnt <= '0;
        cnt       <= '0;
      end else if (acc_restart) begin
        epoch_cnt <= '0;
        cnt       <= CNT_W'(1);
      end else if (acc_add) begin
        if (epoch_i) epoch_cnt <= epoch_cnt + 1'b1;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  // Dump registers capture the accumulators as they stood before the closing
  // epoch sample, and are held untouched while a result is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_valid_o <= 1'b0;
      dump_i_o     <= '0;
      dump_q_o     <= '0;
      dump_cnt_o   <= '0;
    end else if (dump_take) begin
      dump_valid_o <= 1'b1;
      dump_i_o     <= acc_i;
      dump_q_o     <= acc_q;
      dump_cnt_o   <= cnt;
    end else if (dump_valid_o && dump_ready_i) begin
      dump_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_o <= 1'b0;
    end else if (!en_i) begin
      overrun_o <= 1'b0;
    end else if (dump_fire && !dump_take) begin
      overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ca_prompt_correlator.sv
// ---------------------------------------------------------------------------
// tb_ca_prompt_correlator
// Three correlator instances share one stimulus stream:
//   dut_a - defaults (NUM_EPOCHS=1, ACC_W=16)
//   dut_b - NUM_EPOCHS=3
//   dut_c - ACC_W=8 (saturation)
// Per-epoch scenarios come from a vector table; backpressure, abort and
// asynchronous reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ca_prompt_correlator;

  localparam int SAMPLE_W = 3;

  logic clk;
  logic rst_n;
  logic en;
  logic sample_valid;
  logic signed [SAMPLE_W-1:0] sample_i;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic chip;
  logic epoch;
  logic dump_ready;

  logic              a_valid, b_valid, c_valid;
  logic signed [15:0] a_i, a_q, b_i, b_q;
  logic signed [7:0]  c_i, c_q;
  logic [15:0]        a_cnt, b_cnt, c_cnt;
  logic               a_ovr, b_ovr, c_ovr;

  int checks = 0;
  int errors = 0;

  ca_prompt_correlator dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sample_valid_i(sample_valid),
    .sample_i_i(sample_i), .sample_q_i(sample_q), .chip_i(chip), .epoch_i(epoch),
    .dump_valid_o(a_valid), .dump_ready_i(dump_ready), .dump_i_o(a_i),
    .dump_q_o(a_q), .dump_cnt_o(a_cnt), .overrun_o(a_ovr)
  );

  ca_prompt_correlator #(.NUM_EPOCHS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sample_valid_i(sample_valid),
    .sample_i_i(sample_i), .sample_q_i(sample_q), .chip_i(chip), .epoch_i(epoch),
    .dump_valid_o(b_valid), .dump_ready_i(dump_ready), .dump_i_o(b_i),
    .dump_q_o(b_q), .dump_cnt_o(b_cnt), .overrun_o(b_ovr)
  );

  ca_prompt_correlator #(.ACC_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .en_i(en), .sample_valid_i(sample_valid),
    .sample_i_i(sample_i), .sample_q_i(sample_q), .chip_i(chip), .epoch_i(epoch),
    .dump_valid_o(c_valid), .dump_ready_i(dump_ready), .dump_i_o(c_i),
    .dump_q_o(c_q), .dump_cnt_o(c_cnt), .overrun_o(c_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int si;
    int sq;
    bit alt;   // alternate chip 0/1 per sample
    bit ch;    // constant chip when alt = 0
    int per;   // samples per epoch
    int ei;
    int eq;
    int ecnt;
    int ei8;   // expected I on the 8-bit instance
    int eq8;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 1 time
  // unit after the edge that consumes the sample.
  task automatic send(input logic v, input int si, input int sq,
                      input logic ch, input logic ep);
    sample_valid = v;
    sample_i     = SAMPLE_W'(si);
    sample_q     = SAMPLE_W'(sq);
    chip         = ch;
    epoch        = ep;
    @(posedge clk);
    #1;
  endtask

  // Abort any integration and leave the instances waiting for an epoch.
  task automatic restart_int();
    dump_ready = 1'b1;
    en = 1'b0;
    send(1'b0, 0, 0, 1'b0, 1'b0);
    en = 1'b1;
    send(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{si:  1, sq: -1, alt: 0, ch: 0, per: 10, ei:   10, eq:  -10, ecnt: 10, ei8:   10, eq8:  -10};
    vecs[1] = '{si:  2, sq:  1, alt: 1, ch: 0, per: 10, ei:    0, eq:    0, ecnt: 10, ei8:    0, eq8:    0};
    vecs[2] = '{si: -4, sq:  3, alt: 0, ch: 1, per:  5, ei:   20, eq:  -15, ecnt:  5, ei8:   20, eq8:  -15};
    vecs[3] = '{si: -2, sq: -3, alt: 0, ch: 0, per:  7, ei:  -14, eq:  -21, ecnt:  7, ei8:  -14, eq8:  -21};
    vecs[4] = '{si:  3, sq: -3, alt: 0, ch: 0, per: 60, ei:  180, eq: -180, ecnt: 60, ei8:  127, eq8: -128};
    vecs[5] = '{si:  3, sq: -3, alt: 0, ch: 1, per: 60, ei: -180, eq:  180, ecnt: 60, ei8: -128, eq8:  127};

    rst_n = 1'b0;
    en = 1'b0;
    sample_valid = 1'b0;
    sample_i = '0;
    sample_q = '0;
    chip = 1'b0;
    epoch = 1'b0;
    dump_ready = 1'b1;

    // Reset state
    #3;
    check("rst_valid", int'(a_valid), 0);
    check("rst_dump_i", int'(a_i), 0);
    check("rst_dump_cnt", int'(a_cnt), 0);
    check("rst_overrun", int'(a_ovr), 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven epoch scenarios: 5 pre-epoch samples that must be ignored,
    // then three periods; dumps checked at the two closing epoch samples.
    for (int n = 0; n < 6; n++) begin
      restart_int();
      for (int k = 0; k < 5; k++)
        send(1'b1, vecs[n].si, vecs[n].sq, vecs[n].ch, 1'b0);
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < vecs[n].per; k++) begin
          logic ch_k;
          ch_k = vecs[n].alt ? ((k % 2) == 1) : vecs[n].ch;
          send(1'b1, vecs[n].si, vecs[n].sq, ch_k, k == 0);
          if (p > 0 && k == 0) begin
            check($sformatf("v%0d_p%0d_valid", n, p), int'(a_valid), 1);
            check($sformatf("v%0d_p%0d_i", n, p), int'(a_i), vecs[n].ei);
            check($sformatf("v%0d_p%0d_q", n, p), int'(a_q), vecs[n].eq);
            check($sformatf("v%0d_p%0d_cnt", n, p), int'(a_cnt), vecs[n].ecnt);
            check($sformatf("v%0d_p%0d_i8", n, p), int'(c_i), vecs[n].ei8);
            check($sformatf("v%0d_p%0d_q8", n, p), int'(c_q), vecs[n].eq8);
          end
          if (p > 0 && k == 1)
            check($sformatf("v%0d_p%0d_clear", n, p), int'(a_valid), 0);
        end
      end
    end

    // Multi-epoch: 3 epochs of 4 samples of +3 -> I=36, cnt=12
    restart_int();
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < 4; k++) begin
        send(1'b1, 3, 0, 1'b0, k == 0);
        if (k == 0 && (p == 3 || p == 6)) begin
          check($sformatf("multi_p%0d_valid", p), int'(b_valid), 1);
          check($sformatf("multi_p%0d_i", p), int'(b_i), 36);
          check($sformatf("multi_p%0d_cnt", p), int'(b_cnt), 12);
        end
        if (k == 0 && (p == 1 || p == 2 || p == 4))
          check($sformatf("multi_p%0d_nodump", p), int'(b_valid), 0);
        if (k == 1 && p == 3)
          check("multi_clear", int'(b_valid), 0);
      end
    end

    // Backpressure: first dump (I=4) held, second (would be I=8) dropped
    restart_int();
    dump_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(1'b1, 1, 0, 1'b0, k == 0);
    send(1'b1, 2, 0, 1'b0, 1'b1);
    check("bp_first_valid", int'(a_valid), 1);
    check("bp_first_i", int'(a_i), 4);
    for (int k = 1; k < 4; k++) send(1'b1, 2, 0, 1'b0, 1'b0);
    send(1'b1, 1, 0, 1'b0, 1'b1);
    check("bp_held_valid", int'(a_valid), 1);
    check("bp_held_i", int'(a_i), 4);
    check("bp_held_cnt", int'(a_cnt), 4);
    check("bp_overrun", int'(a_ovr), 1);
    dump_ready = 1'b1;
    check("bp_deliver_i", int'(a_i), 4);
    send(1'b1, 1, 0, 1'b0, 1'b0);
    check("bp_after_valid", int'(a_valid), 0);
    check("bp_overrun_sticky", int'(a_ovr), 1);

    // Abort: 6 samples, then en low coinciding with an epoch sample
    send(1'b1, 1, 0, 1'b0, 1'b1);
    for (int k = 1; k < 6; k++) send(1'b1, 1, 0, 1'b0, 1'b0);
    en = 1'b0;
    send(1'b1, 1, 0, 1'b0, 1'b1);
    check("abort_nodump", int'(a_valid), 0);
    check("abort_overrun", int'(a_ovr), 0);
    en = 1'b1;
    send(1'b1, 3, 0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send(1'b1, 3, 0, 1'b0, 1'b0);
    check("abort_wait", int'(a_valid), 0);
    for (int k = 0; k < 5; k++) send(1'b1, 1, 0, 1'b0, k == 0);
    dump_ready = 1'b0;
    send(1'b1, 1, 0, 1'b0, 1'b1);
    check("reen_valid", int'(a_valid), 1);
    check("reen_i", int'(a_i), 5);
    check("reen_cnt", int'(a_cnt), 5);

    // Asynchronous reset while a dump is pending
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(a_valid), 0);
    check("arst_i", int'(a_i), 0);
    check("arst_cnt", int'(a_cnt), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ca_prompt_correlator.md
Name: ca_prompt_correlator

Overview:
- Downstream consumer of the GPS L1 C/A code generator.
- Multiplies each incoming baseband I/Q sample by the current prompt C/A chip and accumulates over an integration period of NUM_EPOCHS code epochs (1 epoch = 1023 chips = 1 ms).
- Presents the I/Q dump to the tracking/acquisition logic through a valid/ready handshake.

Parameters:
- SAMPLE_W, 3: signed two's-complement width of I/Q samples.
- ACC_W, 16: signed accumulator and dump width.
- CNT_W, 16: sample-count width; saturates at all-ones.
- NUM_EPOCHS, 1: code epochs per integration, range 1..20.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  1  correlator enable; low = idle, partial integration discarded.
- sample_valid_i  in  1  qualifies sample_i_i, sample_q_i, chip_i, epoch_i.
- sample_i_i  in  SAMPLE_W  in-phase sample, signed.
- sample_q_i  in  SAMPLE_W  quadrature sample, signed.
- chip_i  in  1  prompt C/A chip aligned to the sample (0 maps to +1, 1 maps to -1).
- epoch_i  in  1  sample is the first sample of chip 1 of a new code period.
- dump_valid_o  out  1  dump result available.
- dump_ready_i  in  1  consumer accepts dump.
- dump_i_o  out  ACC_W  integrated I.
- dump_q_o  out  ACC_W  integrated Q.
- dump_cnt_o  out  CNT_W  samples integrated.
- overrun_o  out  1  sticky: a dump was lost to backpressure.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - Accumulators, epoch counter and all dump outputs = 0.
  - dump_valid_o = 0, overrun_o = 0.
- All inputs are ignored unless sample_valid_i = 1.
- State IDLE: accumulators held at 0.
  - en_i = 1 -> WAIT_EPOCH.
- State WAIT_EPOCH: samples are discarded.
  - A qualified sample with epoch_i = 1 -> ACCUM.
  - That sample is the first one accumulated; epoch counter = 0.
- State ACCUM, qualified sample with epoch_i = 0:
  - acc_i += ±sample_i_i and acc_q += ±sample_q_i (sign per chip_i); cnt += 1.
- State ACCUM, qualified sample with epoch_i = 1: epoch counter += 1.
  - If the counter reaches NUM_EPOCHS, a dump occurs.
  - Dump registers load the accumulators as they stood before this sample.
  - Accumulators restart with this sample's product; cnt = 1; epoch counter = 0.
- Latency: dump_valid_o rises on the clock edge that consumes the closing epoch sample.
  - Data is registered and stable while dump_valid_o = 1.
- Arithmetic:
  - Product is sign-extended to ACC_W.
  - Accumulation saturates at +(2^(ACC_W-1)-1) and -2^(ACC_W-1); there is no wrap.
  - Negating the most negative SAMPLE_W value yields +2^(SAMPLE_W-1); this must be representable in the sign extension.
  - cnt saturates at 2^CNT_W-1.
- Handshake:
  - Transfer occurs when dump_valid_o && dump_ready_i.
  - dump_valid_o then clears on the next edge unless a new dump occurs on that same edge, in which case it stays 1 with the new data.
- Backpressure:
  - A new dump while dump_valid_o = 1 and dump_ready_i = 0 is dropped.
  - The pending dump is held unchanged and overrun_o is set.
- en_i low in any state: next state IDLE.
  - Accumulators and epoch counter clear.
  - A pending dump stays valid until accepted.
  - overrun_o clears.
- en_i reasserted: must wait for a fresh epoch; there is no resumption.
- Simultaneous epoch and en_i falling: en_i has priority and no dump occurs.

Decomposition:
- Package ca_corr_pkg holds:
  - State enum {IDLE, WAIT_EPOCH, ACCUM}.
  - Constant CA_CODE_LEN = 1023.
  - Function chip_to_sign.
  - Saturating-add function sat_add(acc, val).
- One sub-module, ca_corr_acc, is instantiated twice (I and Q). It contains the signed multiply-by-±1 and the saturating accumulator with clear/restart controls.
- FSM, epoch counter, dump registers and handshake live in the top.

Test Plan:
- Baseline: NUM_EPOCHS=1, I=+1, Q=-1, chip=0, epoch every 10 samples, ready=1.
  - Dumps of I=10, Q=-10, cnt=10 each period.
- Alignment: 5 samples before the first epoch are ignored.
  - Alternating chip 0/1 with I=+2 -> dump_i=0, cnt=10.
- Multi-epoch: NUM_EPOCHS=3, I=+3, epoch every 4 samples.
  - Single dump with I=36, cnt=12 every 12 samples.
- Saturation: ACC_W=8, I=+3, chip=0, 60 samples/epoch -> dump_i=127.
  - With chip=1 -> -128.
- Backpressure: ready=0 across two dump points.
  - First dump held with its values, second dropped, overrun_o=1.
  - Raising ready delivers the first dump; dump_valid_o then clears.
- Abort: en_i low mid-integration after 6 samples.
  - No dump and overrun_o=0.
  - After re-enable, the first dump contains only post-epoch samples.
  - Async rst_n mid-dump clears dump_valid_o immediately.
